ct_spsram_512x52_ctrl: RTL and testbench

- Access controller directly upstream of the 512x52 single-port SRAM wrapper; drives its A/CEN/GWEN/WEN/D pins and consumes Q.
- Clears the array after reset or on request, then converts a valid/ready request stream into SRAM accesses.
- Captures the one-cycle-late read data into a 2-entry response buffer, so the consumer may backpressure without losing data.

---
 rtl/ct_spsram_ctrl_pkg.sv | 13 +
 rtl/ct_spsram_rsp_fifo.sv | 33 +++
 rtl/ct_spsram_512x52_ctrl.sv | 72 +++++++
 tb/tb_ct_spsram_512x52_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_spsram_ctrl_pkg.sv
// ct_spsram_ctrl_pkg: shared constants, state encoding and request bundle for the SRAM controller
package ct_spsram_ctrl_pkg;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 52;
  localparam int DEPTH = 512;
  typedef enum logic [1:0] {INIT, IDLE, DRAIN} state_t;
  typedef struct packed {
    logic wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wmask;
  } req_t;
endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// ct_spsram_rsp_fifo: 2-entry in-order response buffer with count
module ct_spsram_rsp_fifo #(
  parameter int W = 52
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full,
  output logic         empty,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= d;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
  assign q = mem[rp];
  assign empty = cnt == 2'd0;
  assign full = cnt == 2'd2;
endmodule

// File: rtl/ct_spsram_512x52_ctrl.sv
// ct_spsram_512x52_ctrl: clears the 512x52 SRAM, then serves valid/ready requests with buffered read data
module ct_spsram_512x52_ctrl #(
  parameter int ADDR_WIDTH = ct_spsram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ct_spsram_ctrl_pkg::DATA_WIDTH,
  parameter int DEPTH = ct_spsram_ctrl_pkg::DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_cen,
  output logic                  mem_gwen,
  output logic [DATA_WIDTH-1:0] mem_wen,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  import ct_spsram_ctrl_pkg::*;
  state_t state, state_n;
  req_t req;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic rd_pend, pop, push, acc, wr_acc, rd_acc, credit_ok, in_init, clear;
  logic fifo_full, fifo_empty;
  logic [1:0] fifo_cnt;
  assign req = '{wr: req_wr, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
  ct_spsram_rsp_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk(CLK), .rst(RST), .push(push), .pop(pop), .d(mem_q),
    .q(rsp_data), .full(fifo_full), .empty(fifo_empty), .cnt(fifo_cnt)
  );
  always_comb begin
    in_init = state == INIT;
    rsp_vld = !RST && !fifo_empty;
    pop = rsp_vld && rsp_rdy;
    push = rd_pend && !(fifo_full && !pop);
    clear = !rd_pend && fifo_empty;
    credit_ok = ({1'b0, fifo_cnt} + {2'b0, rd_pend} - {2'b0, pop}) < 3'd2;
    init_done = !RST && state == IDLE;
    req_rdy = init_done && !init_req && (req.wr || credit_ok);
    acc = req_vld && req_rdy;
    wr_acc = acc && req.wr;
    rd_acc = acc && !req.wr;
    mem_cen = RST ? 1'b1 : in_init ? 1'b0 : !acc;
    mem_gwen = RST ? 1'b1 : in_init ? 1'b0 : !wr_acc;
    mem_wen = RST ? '1 : in_init ? '0 : wr_acc ? ~req.wmask : rd_acc ? '1 : '0;
    mem_a = RST ? '0 : in_init ? init_cnt : acc ? req.addr : '0;
    mem_d = RST ? '0 : in_init ? INIT_VALUE : wr_acc ? req.wdata : '0;
    state_n = in_init ? (init_cnt == ADDR_WIDTH'(DEPTH - 1) ? IDLE : INIT)
            : state == IDLE ? (init_req ? (clear ? INIT : DRAIN) : IDLE)
            : (clear ? INIT : DRAIN);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      init_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      state <= state_n;
      init_cnt <= in_init ? init_cnt + 1'b1 : '0;
      rd_pend <= rd_acc;
    end
  end
endmodule

// File: tb/tb_ct_spsram_512x52_ctrl.sv
// tb_ct_spsram_512x52_ctrl: directed self-checking bench with a behavioural SRAM model
module tb_ct_spsram_512x52_ctrl;
  logic CLK = 1'b0, RST = 1'b1, init_req = 1'b0, init_done;
  logic req_vld = 1'b0, req_rdy, req_wr = 1'b0;
  logic [8:0] req_addr = '0;
  logic [51:0] req_wdata = '0, req_wmask = '0;
  logic rsp_vld, rsp_rdy = 1'b1;
  logic [51:0] rsp_data;
  logic [8:0] mem_a;
  logic mem_cen, mem_gwen;
  logic [51:0] mem_wen, mem_d, mem_q;
  logic [51:0] sram [512];
  int vec = 0, errs = 0;
  localparam logic [51:0] ONES = '1;
  localparam logic [51:0] D0 = 52'h1_1111_2222_3333;
  localparam logic [51:0] D1 = 52'h4_4444_5555_6666;
  localparam logic [51:0] D2 = 52'h7_7777_8888_9999;
  ct_spsram_512x52_ctrl dut (
    .CLK(CLK), .RST(RST), .init_req(init_req), .init_done(init_done),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data), .mem_a(mem_a), .mem_cen(mem_cen), .mem_gwen(mem_gwen),
    .mem_wen(mem_wen), .mem_d(mem_d), .mem_q(mem_q)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK)
    if (!mem_cen) begin
      if (!mem_gwen) sram[mem_a] <= (sram[mem_a] & mem_wen) | (mem_d & ~mem_wen);
      else mem_q <= sram[mem_a];
    end
  task automatic sweep_check(input string name, input logic chk_rsp);
    logic [117:0] obs, exp;
    for (int i = 0; i < 512; i++) begin
      obs = {mem_cen, mem_gwen, mem_wen, mem_a, mem_d, req_rdy, init_done, chk_rsp & rsp_vld};
      exp = {2'b00, 52'h0, 9'(i), 52'h0, 3'b000};
      vec++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, exp);
      end
      @(negedge CLK);
      #1;
    end
    vec++;
    if (init_done !== 1'b1) begin errs++; $display("FAIL %s init_done: got %b expected 1", name, init_done); end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge CLK);
    #1;
    vec++;
    if ({mem_cen, mem_gwen, mem_wen, init_done, req_rdy, rsp_vld} !== {2'b11, ONES, 3'b000}) begin
      errs++;
      $display("FAIL reset_pins: got cen=%b gwen=%b wen=%h done=%b rdy=%b vld=%b expected 1 1 all-1 0 0 0",
               mem_cen, mem_gwen, mem_wen, init_done, req_rdy, rsp_vld);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    sweep_check("reset_sweep", 1'b1);
  endtask
  task automatic test_write_read;
    @(negedge CLK);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'h1A5; req_wdata = 52'hA_BCDE_F012_3456; req_wmask = ONES;
    #1;
    vec++;
    if ({req_rdy, mem_cen, mem_gwen, mem_wen, mem_a, mem_d} !== {3'b100, 52'h0, 9'h1A5, 52'hA_BCDE_F012_3456}) begin
      errs++;
      $display("FAIL wr_pins: got rdy=%b cen=%b gwen=%b wen=%h a=%h d=%h", req_rdy, mem_cen, mem_gwen, mem_wen, mem_a, mem_d);
    end
    @(negedge CLK);
    req_wr = 1'b0;
    #1;
    vec++;
    if ({req_rdy, mem_cen, mem_gwen, mem_wen, mem_a} !== {3'b101, ONES, 9'h1A5}) begin
      errs++;
      $display("FAIL rd_pins: got rdy=%b cen=%b gwen=%b wen=%h a=%h", req_rdy, mem_cen, mem_gwen, mem_wen, mem_a);
    end
    @(negedge CLK);
    req_vld = 1'b0;
    #1;
    vec++;
    if (rsp_vld !== 1'b0) begin errs++; $display("FAIL rd_latency_early: rsp_vld got %b expected 0", rsp_vld); end
    @(negedge CLK);
    #1;
    vec++;
    if (rsp_vld !== 1'b1 || rsp_data !== 52'hA_BCDE_F012_3456) begin
      errs++;
      $display("FAIL rd_data: got vld=%b data=%h expected 1 abcdef0123456", rsp_vld, rsp_data);
    end
    @(negedge CLK);
    #1;
    vec++;
    if (rsp_vld !== 1'b0) begin errs++; $display("FAIL rd_popped: rsp_vld got %b expected 0", rsp_vld); end
  endtask
  task automatic test_partial_write;
    @(negedge CLK);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'd7; req_wdata = ONES; req_wmask = 52'h000_0000_FFFF;
    #1;
    vec++;
    if (req_rdy !== 1'b1 || mem_wen !== 52'hF_FFFF_FFFF_0000) begin
      errs++;
      $display("FAIL partial_wen: got rdy=%b wen=%h expected 1 fffffffff0000", req_rdy, mem_wen);
    end
    @(negedge CLK);
    req_wr = 1'b0;
    @(negedge CLK);
    req_vld = 1'b0;
    @(negedge CLK);
    #1;
    vec++;
    if (rsp_vld !== 1'b1 || rsp_data !== 52'h0_0000_0000_FFFF) begin
      errs++;
      $display("FAIL partial_data: got vld=%b data=%h expected 1 000000000ffff", rsp_vld, rsp_data);
    end
  endtask
  task automatic test_backpressure;
    logic [51:0] d [3];
    d[0] = D0; d[1] = D1; d[2] = D2;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'(10 + i); req_wdata = d[i]; req_wmask = ONES;
      #1;
      vec++;
      if (req_rdy !== 1'b1) begin errs++; $display("FAIL bp_write%0d: req_rdy got %b expected 1", i, req_rdy); end
    end
    @(negedge CLK);
    rsp_rdy = 1'b0; req_wr = 1'b0; req_addr = 9'd10;
    #1;
    vec++;
    if (req_rdy !== 1'b1) begin errs++; $display("FAIL bp_rd0_rdy: got %b expected 1", req_rdy); end
    @(negedge CLK);
    req_addr = 9'd11;
    #1;
    vec++;
    if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
      errs++;
      $display("FAIL bp_rd1: got rdy=%b vld=%b expected 1 0", req_rdy, rsp_vld);
    end
    @(negedge CLK);
    req_addr = 9'd12;
    #1;
    vec++;
    if ({req_rdy, mem_cen, rsp_vld} !== 3'b011 || rsp_data !== D0) begin
      errs++;
      $display("FAIL bp_rd2_block: got rdy=%b cen=%b vld=%b data=%h expected 0 1 1 %h", req_rdy, mem_cen, rsp_vld, rsp_data, D0);
    end
    @(negedge CLK);
    #1;
    vec++;
    if (req_rdy !== 1'b0 || rsp_data !== D0) begin
      errs++;
      $display("FAIL bp_hold: got rdy=%b data=%h expected 0 %h", req_rdy, rsp_data, D0);
    end
    @(negedge CLK);
    rsp_rdy = 1'b1;
    #1;
    vec++;
    if ({req_rdy, mem_cen} !== 2'b10 || rsp_data !== D0) begin
      errs++;
      $display("FAIL bp_release: got rdy=%b cen=%b data=%h expected 1 0 %h", req_rdy, mem_cen, rsp_data, D0);
    end
    @(negedge CLK);
    req_vld = 1'b0;
    #1;
    vec++;
    if (rsp_vld !== 1'b1 || rsp_data !== D1) begin
      errs++;
      $display("FAIL bp_second: got vld=%b data=%h expected 1 %h", rsp_vld, rsp_data, D1);
    end
    @(negedge CLK);
    #1;
    vec++;
    if (rsp_vld !== 1'b1 || rsp_data !== D2) begin
      errs++;
      $display("FAIL bp_third: got vld=%b data=%h expected 1 %h", rsp_vld, rsp_data, D2);
    end
    @(negedge CLK);
    #1;
    vec++;
    if (rsp_vld !== 1'b0) begin errs++; $display("FAIL bp_empty: rsp_vld got %b expected 0", rsp_vld); end
  endtask
  task automatic test_init_drain;
    @(negedge CLK);
    rsp_rdy = 1'b0; req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'd10;
    #1;
    vec++;
    if (req_rdy !== 1'b1) begin errs++; $display("FAIL drain_rd_rdy: got %b expected 1", req_rdy); end
    @(negedge CLK);
    req_vld = 1'b0; init_req = 1'b1;
    #1;
    vec++;
    if (req_rdy !== 1'b0 || init_done !== 1'b1) begin
      errs++;
      $display("FAIL drain_req: got rdy=%b done=%b expected 0 1", req_rdy, init_done);
    end
    @(negedge CLK);
    init_req = 1'b0; req_vld = 1'b1;
    #1;
    vec++;
    if ({init_done, req_rdy, mem_cen, rsp_vld} !== 4'b0011 || rsp_data !== D0) begin
      errs++;
      $display("FAIL drain_state: got done=%b rdy=%b cen=%b vld=%b data=%h expected 0 0 1 1 %h",
               init_done, req_rdy, mem_cen, rsp_vld, rsp_data, D0);
    end
    @(negedge CLK);
    rsp_rdy = 1'b1;
    #1;
    vec++;
    if (rsp_vld !== 1'b1 || rsp_data !== D0) begin
      errs++;
      $display("FAIL drain_hold: got vld=%b data=%h expected 1 %h", rsp_vld, rsp_data, D0);
    end
    @(negedge CLK);
    req_vld = 1'b0;
    #1;
    vec++;
    if ({rsp_vld, mem_cen, init_done} !== 3'b010) begin
      errs++;
      $display("FAIL drain_done: got vld=%b cen=%b done=%b expected 0 1 0", rsp_vld, mem_cen, init_done);
    end
    @(negedge CLK);
    #1;
    sweep_check("drain_sweep", 1'b1);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'd10;
    @(negedge CLK);
    req_addr = 9'h1A5;
    @(negedge CLK);
    req_vld = 1'b0;
    #1;
    vec++;
    if (rsp_vld !== 1'b1 || rsp_data !== 52'h0) begin
      errs++;
      $display("FAIL cleared_a: got vld=%b data=%h expected 1 0", rsp_vld, rsp_data);
    end
    @(negedge CLK);
    #1;
    vec++;
    if (rsp_vld !== 1'b1 || rsp_data !== 52'h0) begin
      errs++;
      $display("FAIL cleared_b: got vld=%b data=%h expected 1 0", rsp_vld, rsp_data);
    end
  endtask
  task automatic test_reset_mid_sweep;
    @(negedge CLK);
    init_req = 1'b1;
    #1;
    vec++;
    if (req_rdy !== 1'b0) begin errs++; $display("FAIL mid_req: req_rdy got %b expected 0", req_rdy); end
    @(negedge CLK);
    init_req = 1'b0;
    repeat (200) @(negedge CLK);
    #1;
    vec++;
    if (mem_a !== 9'd200 || mem_cen !== 1'b0) begin
      errs++;
      $display("FAIL mid_at200: got a=%0d cen=%b expected 200 0", mem_a, mem_cen);
    end
    RST = 1'b1;
    #1;
    vec++;
    if (mem_cen !== 1'b1 || rsp_vld !== 1'b0) begin
      errs++;
      $display("FAIL mid_rst_pins: got cen=%b vld=%b expected 1 0", mem_cen, rsp_vld);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    sweep_check("mid_sweep", 1'b1);
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_partial_write;
    test_backpressure;
    test_init_drain;
    test_reset_mid_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
